// File: rtl/aes128_pkg.sv
// Shared AES-128 definitions: round count, datapath width, FSM encoding,
// the S-box lookup, the round-constant table and the GF(2^8) doubling helper.
package aes128_pkg;

   localparam int AES_NR  = 10;
   localparam int STATE_W = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } aesFsm_e;

   // One row per high nibble of the input byte; byte 0 of a row sits in the top bits.
   localparam logic [127:0] SBOX_ROW [16] = '{
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_ROW[b[7:4]][{~b[3:0], 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] rc;
      case (r)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

endpackage

// File: rtl/aes128_round_stage.sv
// One combinational AES-128 round fused with the key-schedule step that
// produces that round's key; the final round bypasses MixColumns.
module aes128_round_stage
   import aes128_pkg::*;
(
   input  logic [STATE_W-1:0] state_i,
   input  logic [STATE_W-1:0] key_i,
   input  logic [7:0]         rcon_i,
   input  logic               lastRound_i,
   output logic [STATE_W-1:0] state_o,
   output logic [STATE_W-1:0] key_o
);

   logic [7:0]         subB   [16];
   logic [7:0]         shiftB [16];
   logic [7:0]         mixB   [16];
   logic [STATE_W-1:0] preKey;
   logic [31:0]        rotSub;
   logic [31:0]        w0, w1, w2, w3;

   // Bytes are column-major: byte i is row i%4 of column i/4.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         subB[i] = sbox(state_i[127-8*i -: 8]);
      end
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shiftB[4*c+r] = subB[4*((c+r)%4)+r];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mixB[4*c+0] = xtime(shiftB[4*c+0]) ^ xtime(shiftB[4*c+1]) ^ shiftB[4*c+1]
                     ^ shiftB[4*c+2] ^ shiftB[4*c+3];
         mixB[4*c+1] = shiftB[4*c+0] ^ xtime(shiftB[4*c+1]) ^ xtime(shiftB[4*c+2])
                     ^ shiftB[4*c+2] ^ shiftB[4*c+3];
         mixB[4*c+2] = shiftB[4*c+0] ^ shiftB[4*c+1] ^ xtime(shiftB[4*c+2])
                     ^ xtime(shiftB[4*c+3]) ^ shiftB[4*c+3];
         mixB[4*c+3] = xtime(shiftB[4*c+0]) ^ shiftB[4*c+0] ^ shiftB[4*c+1]
                     ^ shiftB[4*c+2] ^ xtime(shiftB[4*c+3]);
      end
      for (int i = 0; i < 16; i++) begin
         preKey[127-8*i -: 8] = lastRound_i ? shiftB[i] : mixB[i];
      end
   end

   assign rotSub = {sbox(key_i[23:16]), sbox(key_i[15:8]), sbox(key_i[7:0]), sbox(key_i[31:24])}
                 ^ {rcon_i, 24'h000000};
   assign w0 = key_i[127:96] ^ rotSub;
   assign w1 = key_i[95:64]  ^ w0;
   assign w2 = key_i[63:32]  ^ w1;
   assign w3 = key_i[31:0]   ^ w2;

   assign key_o   = {w0, w1, w2, w3};
   assign state_o = preKey ^ key_o;

endmodule

// File: rtl/aes128_iter_engine.sv
// Iterative AES-128 encryptor with UNROLL chained round stages per clock and
// valid/ready handshakes; AES_BACK2BACK_EN lets DONE accept the next block directly.
module aes128_iter_engine
   import aes128_pkg::*;
#(
   parameter int UNROLL = 1
)
(
   input  logic               iClk,
   input  logic               iRst,
   input  logic               iInValid,
   output logic               oInReady,
   input  logic [STATE_W-1:0] iAesKey,
   input  logic [STATE_W-1:0] iPlainText,
   output logic               oOutValid,
   input  logic               iOutReady,
   output logic [STATE_W-1:0] oCpText,
   output logic               oBusy
);

   if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : gBadUnroll
      $error("aes128_iter_engine: UNROLL must be 1, 2, 5 or 10");
   end

   aesFsm_e            fsm_q;
   logic [3:0]         rcnt_q, rcnt_d;
   logic [STATE_W-1:0] data_q, data_d;
   logic [STATE_W-1:0] key_q, key_d;
   logic               inReady_q, outValid_q, busy_q;
   logic               lastStep;

   logic [STATE_W-1:0] stgState [UNROLL+1];
   logic [STATE_W-1:0] stgKey   [UNROLL+1];

   assign stgState[0] = data_q;
   assign stgKey[0]   = key_q;

   // The round constant follows the absolute round number, not the stage position.
   for (genvar g = 0; g < UNROLL; g++) begin : gStage
      logic [3:0] stgRound;
      assign stgRound = rcnt_q + 4'(g);
      aes128_round_stage uStage (
         .state_i     (stgState[g]),
         .key_i       (stgKey[g]),
         .rcon_i      (rcon(stgRound)),
         .lastRound_i (stgRound == 4'(AES_NR)),
         .state_o     (stgState[g+1]),
         .key_o       (stgKey[g+1])
      );
   end

   assign data_d   = stgState[UNROLL];
   assign key_d    = stgKey[UNROLL];
   assign rcnt_d   = rcnt_q + 4'(UNROLL);
   assign lastStep = (rcnt_q + 4'(UNROLL - 1)) == 4'(AES_NR);

   always_ff @(posedge iClk) begin
      if (iRst) begin
         fsm_q      <= IDLE;
         rcnt_q     <= '0;
         data_q     <= '0;
         key_q      <= '0;
         inReady_q  <= 1'b1;
         outValid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (fsm_q)
            IDLE: begin
               if (iInValid) begin
                  data_q    <= iPlainText ^ iAesKey;
                  key_q     <= iAesKey;
                  rcnt_q    <= 4'd1;
                  fsm_q     <= ROUND;
                  inReady_q <= 1'b0;
                  busy_q    <= 1'b1;
               end
            end
            ROUND: begin
               data_q <= data_d;
               key_q  <= key_d;
               rcnt_q <= rcnt_d;
               if (lastStep) begin
                  fsm_q      <= DONE;
                  outValid_q <= 1'b1;
               end
            end
            DONE: begin
               if (iOutReady) begin
                  outValid_q <= 1'b0;
`ifdef AES_BACK2BACK_EN
                  if (iInValid) begin
                     data_q <= iPlainText ^ iAesKey;
                     key_q  <= iAesKey;
                     rcnt_q <= 4'd1;
                     fsm_q  <= ROUND;
                  end else begin
                     fsm_q     <= IDLE;
                     inReady_q <= 1'b1;
                     busy_q    <= 1'b0;
                  end
`else
                  fsm_q     <= IDLE;
                  inReady_q <= 1'b1;
                  busy_q    <= 1'b0;
`endif
               end
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

`ifdef AES_BACK2BACK_EN
   // Readiness in DONE tracks the sink so a new block can load as the result leaves.
   assign oInReady = inReady_q | ((fsm_q == DONE) & iOutReady);
`else
   assign oInReady = inReady_q;
`endif
   assign oOutValid = outValid_q;
   assign oCpText   = data_q;
   assign oBusy     = busy_q;

endmodule

// File: tb/tb_aes128_iter_engine.sv
// Scoreboard bench: four engines (UNROLL 1, 2, 5, 10) driven by independent lanes,
// checked against a textbook FIPS-197 cipher model built from GF(2^8) arithmetic.
module tb_aes128_iter_engine;

   localparam int WAIT   = 300;
   localparam int MAXCYC = 40000;
   localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
`ifdef AES_BACK2BACK_EN
   localparam int B2B = 1;
`else
   localparam int B2B = 0;
`endif

   typedef struct {
      logic [127:0] ct;
      int           acc;
   } expItem_t;

   logic       clk;
   int         cyc = 0;
   int         checkCount = 0;
   int         failCount = 0;
   int         doneCount = 0;
   bit         modelReady = 0;
   logic [7:0] sboxTbl [256];

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input int lane, input string name, input logic [127:0] act,
                              input logic [127:0] exp);
      checkCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL lane%0d %s: got %h, expected %h", lane, name, act, exp);
      end
   endtask

   task automatic markDone();
      doneCount++;
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box from its definition: multiplicative inverse followed by the affine map.
   initial begin
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         logic [7:0] xb;
         xb = 8'(x);
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
         end
         sboxTbl[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
      modelReady = 1;
   end

   function automatic logic [127:0] aesModel(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc;
      logic [31:0]  tmp;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sboxTbl[tmp[23:16]], sboxTbl[tmp[15:8]], sboxTbl[tmp[7:0]], sboxTbl[tmp[31:24]]}
                ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) t[i] = sboxTbl[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++)
               for (int r = 0; r < 4; r++)
                  t[4*c+r] = gmul(s[4*c+r], 8'h02) ^ gmul(s[4*c+(r+1)%4], 8'h03)
                           ^ s[4*c+(r+2)%4] ^ s[4*c+(r+3)%4];
            for (int i = 0; i < 16; i++) s[i] = t[i];
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd+i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   for (genvar k = 0; k < 4; k++) begin : gLane
      localparam int U        = (k == 0) ? 1 : (k == 1) ? 2 : (k == 2) ? 5 : 10;
      localparam int LAT      = 10 / U;
      localparam int RST_WAIT = (LAT - 1 < 3) ? LAT - 1 : 3;

      logic         rst, inValid, inReady, outValid, outReady, busy;
      logic [127:0] aesKey, plain, ct;
      expItem_t     expQ [$];
      bit           wasValid = 0;

      aes128_iter_engine #(.UNROLL(U)) uDut (
         .iClk       (clk),
         .iRst       (rst),
         .iInValid   (inValid),
         .oInReady   (inReady),
         .iAesKey    (aesKey),
         .iPlainText (plain),
         .oOutValid  (outValid),
         .iOutReady  (outReady),
         .oCpText    (ct),
         .oBusy      (busy)
      );

      // Monitor: checks presented results, then records any block accepted on the coming edge.
      always @(negedge clk) begin
         if (rst) begin
            expQ.delete();
            wasValid = 0;
         end else begin
            if (expQ.size() == 0) begin
               checkOutput(k, "noBlockNoValid", 128'(outValid), 128'(0));
            end else if (outValid) begin
               if (!wasValid) checkOutput(k, "latency", 128'(cyc), 128'(expQ[0].acc + LAT));
               checkOutput(k, "ciphertext", ct, expQ[0].ct);
               if (outReady) void'(expQ.pop_front());
            end
            wasValid = outValid && !outReady;
            if (inValid && inReady) expQ.push_back('{ct: aesModel(aesKey, plain), acc: cyc + 1});
         end
      end

      task automatic syncDrive();
         @(posedge clk);
         #1;
      endtask

      task automatic scramble();
         if (!inValid) begin
            aesKey = rand128();
            plain  = rand128();
         end
      endtask

      task automatic idle(input int n);
         repeat (n) begin
            syncDrive();
            scramble();
         end
      endtask

      task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt, input bit keep,
                                   output int acc, output bit coinc);
         int guard;
         syncDrive();
         aesKey  = key;
         plain   = pt;
         inValid = 1'b1;
         coinc   = 1'b0;
         for (guard = 0; guard < WAIT; guard++) begin
            @(negedge clk);
            if (inReady && !rst) break;
         end
         coinc = outValid && outReady;
         checkOutput(k, "acceptInTime", 128'(guard < WAIT), 128'(1));
         syncDrive();
         acc     = cyc;
         inValid = keep;
         aesKey  = rand128();
         plain   = rand128();
      endtask

      task automatic waitValid();
         int guard;
         for (guard = 0; guard < WAIT; guard++) begin
            @(negedge clk);
            if (outValid) break;
            scramble();
         end
         checkOutput(k, "validInTime", 128'(guard < WAIT), 128'(1));
         syncDrive();
      endtask

      task automatic waitDrain();
         int guard;
         for (guard = 0; guard < WAIT; guard++) begin
            @(negedge clk);
            if (expQ.size() == 0 && !outValid) break;
            scramble();
         end
         checkOutput(k, "drainInTime", 128'(guard < WAIT), 128'(1));
         syncDrive();
      endtask

      task automatic checkReset(input string tag);
         checkOutput(k, {tag, ".inReady"}, 128'(inReady), 128'(1));
         checkOutput(k, {tag, ".outValid"}, 128'(outValid), 128'(0));
         checkOutput(k, {tag, ".cpText"}, ct, 128'(0));
         checkOutput(k, {tag, ".busy"}, 128'(busy), 128'(0));
      endtask

      initial begin
         int acc;
         int accs [3];
         bit coinc;
         rst = 1'b1; inValid = 1'b0; outReady = 1'b0; aesKey = '0; plain = '0;
         wait (modelReady);
         idle(2);
         rst = 1'b0;
         @(negedge clk);
         checkReset("reset");

         // Reference vectors with the sink always ready.
         outReady = 1'b1;
         applyStimulus(KEY_B, PT_B, 1'b0, acc, coinc);
         waitDrain();
         applyStimulus(KEY_C, PT_C, 1'b0, acc, coinc);
         waitDrain();
         checkOutput(k, "vectorModelB", aesModel(KEY_B, PT_B), 128'h3925841d02dc09fbdc118597196a0b32);

         // Random blocks with random sink delay.
         for (int n = 0; n < 10; n++) begin
            outReady = 1'($urandom_range(0, 1));
            applyStimulus(rand128(), rand128(), 1'b0, acc, coinc);
            waitValid();
            idle($urandom_range(0, 4));
            outReady = 1'b1;
            waitDrain();
         end

         // Backpressure: result held for 20 cycles while input pulses are ignored.
         outReady = 1'b0;
         applyStimulus(rand128(), rand128(), 1'b0, acc, coinc);
         waitValid();
         for (int n = 0; n < 20; n++) begin
            syncDrive();
            inValid = 1'($urandom_range(0, 1));
            aesKey  = rand128();
            plain   = rand128();
            @(negedge clk);
            checkOutput(k, "bpInReady", 128'(inReady), 128'(0));
            checkOutput(k, "bpOutValid", 128'(outValid), 128'(1));
         end
         syncDrive();
         inValid  = 1'b0;
         outReady = 1'b1;
         syncDrive();
         outReady = 1'b0;
         @(negedge clk);
         checkOutput(k, "bpReleaseInReady", 128'(inReady), 128'(1));
         checkOutput(k, "bpReleaseBusy", 128'(busy), 128'(0));
         outReady = 1'b1;
         applyStimulus(rand128(), rand128(), 1'b0, acc, coinc);
         waitDrain();

         // Reset while a block is in flight, then a fresh block.
         outReady = 1'b0;
         applyStimulus(KEY_B, PT_B, 1'b0, acc, coinc);
         idle(RST_WAIT);
         rst = 1'b1;
         syncDrive();
         rst = 1'b0;
         @(negedge clk);
         checkReset("midReset");
         idle(15);
         outReady = 1'b1;
         applyStimulus(KEY_C, PT_C, 1'b0, acc, coinc);
         waitDrain();

         // Streaming: valid and ready held high for three blocks.
         for (int b = 0; b < 3; b++) begin
            applyStimulus(rand128(), rand128(), (b < 2), accs[b], coinc);
            if (b > 0) begin
               checkOutput(k, "streamSpacing", 128'(accs[b] - accs[b-1]), 128'(LAT + 2 - B2B));
               checkOutput(k, "streamCoincide", 128'(coinc), 128'(B2B));
            end
         end
         waitDrain();
         checkOutput(k, "queueEmpty", 128'(expQ.size()), 128'(0));
         markDone();
      end
   end

   initial begin
      for (int i = 0; i < MAXCYC && doneCount < 4; i++) @(posedge clk);
      checkOutput(-1, "allLanesDone", 128'(doneCount), 128'(4));
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
